// File: rtl/fp_alu_issue_queue.sv
// Issue stage in front of a combinational FP ALU: queues {opcode, A, B}, holds ALU inputs
// for a settle window, then captures the result with IEEE-754 class flags.
module fp_alu_issue_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_A,
    input  logic [31:0]              in_B,
    input  logic [1:0]               in_opcode,
    output logic [31:0]              alu_A,
    output logic [31:0]              alu_B,
    output logic [1:0]               alu_opcode,
    input  logic [31:0]              alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic [1:0]               out_opcode,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    cmd_t            mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic [3:0]      settle_q, settle_d;
    logic [31:0]     alu_a_q, alu_b_q, res_q;
    logic [1:0]      alu_op_q, res_op_q;
    logic [3:0]      flags_q, flags_d;
    logic            valid_q;
    logic            push, pop, capture, release_out;
    cmd_t            head;

    assign head     = mem_q[rd_ptr_q];
    // Full check uses pre-pop occupancy so a full queue never accepts, even while popping.
    assign in_ready = !rst && (count_q != CntW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign count_d  = count_q + CntW'(push) - CntW'(pop);

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    settle_d = 4'(SETTLE - 1);
                    state_d  = StExec;
                end
            end
            StExec: begin
                if (settle_q == '0) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    if (count_q != '0) begin
                        pop      = 1'b1;
                        settle_d = 4'(SETTLE - 1);
                        state_d  = StExec;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // {nan, inf, zero, badop}; denormals fall through with no flag.
    always_comb begin
        flags_d    = '0;
        flags_d[3] = (alu_result[30:23] == 8'hFF) && (alu_result[22:0] != '0);
        flags_d[2] = (alu_result[30:23] == 8'hFF) && (alu_result[22:0] == '0);
        flags_d[1] = (alu_result[30:23] == 8'h00) && (alu_result[22:0] == '0);
        flags_d[0] = (alu_op_q == 2'b11);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: in_opcode, a: in_A, b: in_B};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            settle_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            valid_q  <= 1'b0;
            res_q    <= '0;
            res_op_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            count_q  <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                alu_a_q  <= head.a;
                alu_b_q  <= head.b;
                alu_op_q <= head.op;
            end
            if (capture) begin
                valid_q  <= 1'b1;
                res_q    <= alu_result;
                res_op_q <= alu_op_q;
                flags_q  <= flags_d;
            end else if (release_out) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign out_valid  = valid_q;
    assign out_result = res_q;
    assign out_opcode = res_op_q;
    assign out_flags  = flags_q;
    assign count      = count_q;

endmodule

// File: tb/tb_fp_alu_issue_queue.sv
// Bench for fp_alu_issue_queue: bench-side ALU (real, stub or scramble) plus queue-based
// reference model of command order, results and flags.
module tb_fp_alu_issue_queue;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_A, in_B;
    logic [1:0]  in_opcode;
    logic [31:0] alu_A, alu_B;
    logic [1:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [1:0]  out_opcode;
    logic [3:0]  out_flags;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    // 0: real FP arithmetic, 1: fixed stub value, 2: deterministic scramble
    int          alu_mode = 2;
    logic [31:0] stub_val = '0;

    fp_alu_issue_queue #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_A       (in_A),
        .in_B       (in_B),
        .in_opcode  (in_opcode),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_flags  (out_flags),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real sp2real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'h00) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == '0) return {d[63], 31'b0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] scramble(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
        if (op == 2'b11) return 32'h0;
        return a ^ {b[15:0], b[31:16]} ^ {30'b0, op};
    endfunction

    function automatic logic [31:0] alu_model(input int mode, input logic [31:0] sv,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        real ra, rb;
        if (mode == 1) return sv;
        if (mode == 2) return scramble(a, b, op);
        ra = sp2real(a);
        rb = sp2real(b);
        case (op)
            2'b00:   return real2sp(ra + rb);
            2'b01:   return real2sp(ra * rb);
            2'b10:   return real2sp(ra / rb);
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result = alu_model(alu_mode, stub_val, alu_A, alu_B, alu_opcode);

    function automatic logic [3:0] exp_flags(input logic [31:0] r, input logic [1:0] op);
        logic is_max, m_zero;
        is_max = (r[30:23] == 8'hFF);
        m_zero = (r[22:0] == 23'h0);
        return {is_max && !m_zero, is_max && m_zero, (r[30:23] == 8'h00) && m_zero,
                op == 2'b11};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
        in_valid  = v;
        in_A      = a;
        in_B      = b;
        in_opcode = op;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, '0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 2'b01);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        step();
        checks++;
        if ({out_valid, count, alu_A, alu_B, alu_opcode, out_result, out_opcode, out_flags}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b count=%0d aluA=%h aluB=%h aluop=%b res=%h op=%b fl=%b want all 0",
                     out_valid, count, alu_A, alu_B, alu_opcode, out_result, out_opcode,
                     out_flags);
        end
        rst = 1'b0;
        drive(1'b0, '0, '0, '0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        do_reset();
        alu_mode  = 0;
        out_ready = 1'b1;
        drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 2'b00);
        step();  // edge 0
        drive(1'b0, '0, '0, '0);
        checks++;
        if (count !== 3'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_edge0: count=%0d valid=%b want 1/0", count, out_valid);
        end
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (alu_A !== 32'h3F80_0000 || alu_B !== 32'h4000_0000 || alu_opcode !== 2'b00) begin
                errors++;
                $display("FAIL add_alu_stable e%0d: A=%h B=%h op=%b want 3f800000/40000000/00",
                         e, alu_A, alu_B, alu_opcode);
            end
            checks++;
            if (out_valid !== (e == 3)) begin
                errors++;
                $display("FAIL add_valid_timing e%0d: got %b want %b", e, out_valid, e == 3);
            end
        end
        checks++;
        if (out_result !== 32'h4040_0000 || out_flags !== 4'b0000 || out_opcode !== 2'b00) begin
            errors++;
            $display("FAIL add_result: res=%h fl=%b op=%b want 40400000/0000/00",
                     out_result, out_flags, out_opcode);
        end
        step();
        step();
    endtask

    task automatic test_fill();
        logic [31:0] q_res[$];
        logic [1:0]  q_op[$];
        logic [31:0] a, b;
        logic [1:0]  op;
        int          n, last;
        do_reset();
        alu_mode  = 2;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a  = 32'h1100_0000 * i + 32'(i) + 32'h0000_0100;
            b  = ~a + 32'(i * 7);
            op = 2'(i % 3);
            drive(1'b1, a, b, op);
            #1;
            checks++;
            if (in_ready !== (i < 5)) begin
                errors++;
                $display("FAIL fill_in_ready i%0d: got %b want %b", i, in_ready, i < 5);
            end
            if (i < 5) begin
                q_res.push_back(scramble(a, b, op));
                q_op.push_back(op);
            end
            step();
        end
        drive(1'b0, '0, '0, '0);
        checks++;
        if (count !== 3'd4 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: count=%0d valid=%b want 4/1", count, out_valid);
        end
        out_ready = 1'b1;
        n = 0;
        last = 0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            if (out_valid) begin
                checks++;
                if (out_result !== q_res[n] || out_opcode !== q_op[n] ||
                    out_flags !== exp_flags(q_res[n], q_op[n])) begin
                    errors++;
                    $display("FAIL fill_order r%0d: res=%h op=%b fl=%b want %h/%b/%b", n,
                             out_result, out_opcode, out_flags, q_res[n], q_op[n],
                             exp_flags(q_res[n], q_op[n]));
                end
                checks++;
                if (count !== 3'(4 - n)) begin
                    errors++;
                    $display("FAIL fill_count r%0d: got %0d want %0d", n, count, 4 - n);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last != SETTLE + 1) begin
                        errors++;
                        $display("FAIL fill_interval r%0d: got %0d want %0d", n, cyc - last,
                                 SETTLE + 1);
                    end
                end
                last = cyc;
                n++;
            end
            step();
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL fill_drain_count: got %0d results want 5", n);
        end
    endtask

    task automatic test_flags();
        logic [31:0] sv [5];
        logic [3:0]  fl [5];
        logic [1:0]  op;
        sv = '{32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
        fl = '{4'b1000, 4'b0100, 4'b0010, 4'b0000, 4'b0011};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            alu_mode  = 1;
            stub_val  = sv[i];
            out_ready = 1'b0;
            op = (i == 4) ? 2'b11 : 2'b01;
            drive(1'b1, 32'h4040_0000, 32'h3F00_0000, op);
            step();
            drive(1'b0, '0, '0, '0);
            for (int t = 0; t < 20 && !out_valid; t++) step();
            checks++;
            if (out_valid !== 1'b1 || out_result !== sv[i] || out_flags !== fl[i] ||
                out_opcode !== op) begin
                errors++;
                $display("FAIL flags case%0d: valid=%b res=%h fl=%b op=%b want 1/%h/%b/%b", i,
                         out_valid, out_result, out_flags, out_opcode, sv[i], fl[i], op);
            end
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic [1:0]  o;
        logic [3:0]  f;
        do_reset();
        alu_mode  = 2;
        out_ready = 1'b0;
        drive(1'b1, 32'h0123_4567, 32'h89AB_CDEF, 2'b10);
        step();
        drive(1'b1, 32'h7654_3210, 32'hFEDC_BA98, 2'b00);
        step();
        drive(1'b0, '0, '0, '0);
        for (int t = 0; t < 20 && !out_valid; t++) step();
        r = out_result;
        o = out_opcode;
        f = out_flags;
        checks++;
        if (out_valid !== 1'b1 || r !== scramble(32'h0123_4567, 32'h89AB_CDEF, 2'b10)) begin
            errors++;
            $display("FAIL bp_first: valid=%b res=%h want 1/%h", out_valid, r,
                     scramble(32'h0123_4567, 32'h89AB_CDEF, 2'b10));
        end
        for (int t = 0; t < 10; t++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_result !== r || out_opcode !== o || out_flags !== f ||
                count !== 3'd1 || alu_A !== 32'h0123_4567) begin
                errors++;
                $display("FAIL bp_hold t%0d: valid=%b res=%h op=%b fl=%b cnt=%0d aluA=%h want 1/%h/%b/%b/1/01234567",
                         t, out_valid, out_result, out_opcode, out_flags, count, alu_A, r, o, f);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || alu_A !== 32'h7654_3210 || alu_opcode !== 2'b00 ||
            count !== 3'd0) begin
            errors++;
            $display("FAIL bp_release: valid=%b aluA=%h aluop=%b cnt=%0d want 0/76543210/00/0",
                     out_valid, alu_A, alu_opcode, count);
        end
        for (int t = 0; t < 10; t++) step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_mode  = 2;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 32'h0000_5000 + 32'(i), 2'b01);
            step();
        end
        drive(1'b0, '0, '0, '0);
        checks++;
        if (count !== 3'd2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre: count=%0d valid=%b want 2/0", count, out_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || alu_A !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: valid=%b cnt=%0d aluA=%h rdy=%b want 0/0/0/1", out_valid,
                     count, alu_A, in_ready);
        end
        for (int t = 0; t < 20; t++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_result t%0d: valid=%b want 0", t, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] q_res[$];
        logic [1:0]  q_op[$];
        logic [31:0] a, b, prev_res;
        logic [1:0]  op, prev_op;
        logic [3:0]  prev_fl;
        logic        hold;
        int          diff;
        do_reset();
        alu_mode = 2;
        hold = 1'b0;
        prev_res = '0;
        prev_op = '0;
        prev_fl = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== prev_res || out_opcode !== prev_op ||
                    out_flags !== prev_fl) begin
                    errors++;
                    $display("FAIL rand_stable c%0d: valid=%b res=%h op=%b fl=%b want 1/%h/%b/%b",
                             cyc, out_valid, out_result, out_opcode, out_flags, prev_res,
                             prev_op, prev_fl);
                end
            end
            diff = q_res.size() - int'(count);
            checks++;
            if (int'(count) > DEPTH || diff < 0 || diff > 1) begin
                errors++;
                $display("FAIL rand_occupancy c%0d: count=%0d model=%0d", cyc, count,
                         q_res.size());
            end
            out_ready = ($urandom_range(0, 2) != 0);
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[30:23] = 8'hFF;
            b = $urandom;
            op = 2'($urandom_range(0, 3));
            drive(($urandom_range(0, 1) == 1), a, b, op);
            #1;
            if (in_valid && in_ready) begin
                q_res.push_back(scramble(a, b, op));
                q_op.push_back(op);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q_res.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious c%0d: res=%h with empty model", cyc, out_result);
                end else begin
                    if (out_result !== q_res[0] || out_opcode !== q_op[0] ||
                        out_flags !== exp_flags(q_res[0], q_op[0])) begin
                        errors++;
                        $display("FAIL rand_result c%0d: res=%h op=%b fl=%b want %h/%b/%b", cyc,
                                 out_result, out_opcode, out_flags, q_res[0], q_op[0],
                                 exp_flags(q_res[0], q_op[0]));
                    end
                    void'(q_res.pop_front());
                    void'(q_op.pop_front());
                end
            end
            hold = out_valid && !out_ready;
            prev_res = out_result;
            prev_op = out_opcode;
            prev_fl = out_flags;
        end
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        for (int t = 0; t < 200 && q_res.size() > 0; t++) begin
            step();
            if (out_valid) begin
                checks++;
                if (out_result !== q_res[0] || out_opcode !== q_op[0]) begin
                    errors++;
                    $display("FAIL rand_drain: res=%h op=%b want %h/%b", out_result, out_opcode,
                             q_res[0], q_op[0]);
                end
                void'(q_res.pop_front());
                void'(q_op.pop_front());
            end
        end
        checks++;
        if (q_res.size() != 0) begin
            errors++;
            $display("FAIL rand_drain_timeout: %0d results never appeared", q_res.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        test_reset();
        test_add();
        test_fill();
        test_flags();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_alu_issue_queue.md
Name: fp_alu_issue_queue

Overview:
- Sequencing stage directly upstream of the combinational floating-point ALU (add/mul/div).
- Buffers incoming {opcode, A, B} operations in a small FIFO and drives one operation onto the ALU inputs.
- Holds those inputs stable for a programmable settle window, which treats the ALU as a multi-cycle path.
- Captures the ALU result with IEEE-754 class flags and presents it downstream on a valid/ready handshake.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- SETTLE, 2: cycles the ALU inputs are held before the result is captured; range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid && in_ready.
- in_A  input  32  operand A, IEEE-754 single.
- in_B  input  32  operand B, IEEE-754 single.
- in_opcode  input  2  00 add, 01 mul, 10 div, 11 unsupported.
- alu_A  output  32  to ALU A.
- alu_B  output  32  to ALU B.
- alu_opcode  output  2  to ALU opcode.
- alu_result  input  32  from ALU result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_result  output  32  captured result.
- out_opcode  output  2  opcode of the captured operation.
- out_flags  output  4  {nan, inf, zero, badop}.
- count  output  $clog2(DEPTH)+1  FIFO occupancy; excludes the in-flight operation.

Behaviour:
- Reset (rst high at an edge): FIFO emptied, count=0, state IDLE, settle counter 0.
- Reset values of outputs: alu_A=0, alu_B=0, alu_opcode=0, out_valid=0, out_result=0, out_opcode=0, out_flags=0.
- in_ready is 0 while rst is high. Otherwise in_ready = (count != DEPTH).
- Reset during EXEC or DONE discards the in-flight operation and all queued operations; no result is emitted for them.
- Push: happens on in_valid && in_ready. Entries are stored in arrival order.
- in_ready uses pre-pop occupancy, so a full FIFO refuses a push even in a cycle where it pops.
- Simultaneous push and pop when not full: count is unchanged.
- Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE: if count>0, pop the head into alu_A/alu_B/alu_opcode, load the settle counter with SETTLE-1, go to EXEC. Otherwise stay in IDLE.
  - EXEC: if the counter is 0, capture alu_result into out_result, in-flight opcode into out_opcode, compute flags, set out_valid=1, go to DONE. Otherwise decrement the counter.
  - DONE: if out_ready and count>0, clear out_valid, pop the next entry, reload the counter, go to EXEC (back-to-back issue). If out_ready and count==0, clear out_valid and go to IDLE. If out_ready is low, hold all outputs.
- alu_* outputs change only on a pop; between pops they keep their last values and never return to 0 except on reset.
- Latency: a command pushed at edge k into an empty, idle block is popped at edge k+1. out_valid rises at edge k+1+SETTLE (edge k+3 at default).
- Throughput: one result per SETTLE+1 cycles with out_ready held high.
- out_result, out_opcode and out_flags are stable while out_valid && !out_ready.
- Flags are computed from the captured result, with e = bits[30:23] and m = bits[22:0]:
  - nan = (e==FF) && (m!=0).
  - inf = (e==FF) && (m==0); either sign.
  - zero = (e==0) && (m==0); either sign.
  - badop = (opcode==11). The result is captured unchanged; the ALU supplies 0 for opcode 11, so zero is also 1.
  - Denormals raise no flag.

Test Plan:
- Add, idle block: reset, push A=3F800000, B=40000000, op 00 at edge 0 with a real ALU attached -> out_result=40400000, out_flags=0000, out_valid rises at edge 3. alu_A/alu_B are stable from edge 1 until capture.
- Fill and order: out_ready=0, push 6 distinct commands on consecutive cycles -> first 5 accepted (1 in flight, 4 queued, count=4), in_ready=0 on the 6th. Raise out_ready -> 5 results in push order, one every 3 cycles, count decreasing to 0.
- Flags via stub ALU: stub returns 7FC00000 -> flags 1000; FF800000 -> 0100; 80000000 -> 0010; 00000001 -> 0000.
- Unsupported opcode: push op 11, stub returns 00000000 -> out_opcode=11, out_flags=0011.
- Backpressure: result valid, out_ready low for 10 cycles -> outputs unchanged every cycle and the queued entry is not popped. out_ready high -> next operation issues on the same edge out_valid clears.
- Reset mid-operation: rst high for one cycle during EXEC with 2 entries queued -> next cycle out_valid=0, count=0, alu_A=0, in_ready=1. No result appears during the following 20 cycles.
